pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Instruction-fetch front end that owns the architectural PC register and drives the instruction-memory request handshake. It consumes the next-PC target produced by branch resolution as a redirect, presents fetched instructions to decode with a valid/ready handshake, and stops fetching after a HLT instruction. It sits between instruction memory and the decode stage, closing the loop with the next-PC logic.

## Interface
- `RESET_PC`, default 16'h0000: PC loaded on reset; must be even.
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `redirect_valid`  in  1  one-cycle pulse: load PC from `redirect_pc`, squash in-flight fetch.
- `redirect_pc`  in  16  redirect target; bit 0 forced to 0 internally.
- `imem_req`  out  1  fetch request; held until `imem_ack`.
- `imem_addr`  out  16  fetch address; stable while `imem_req`=1.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle; may coincide with first `imem_req` cycle.
- `imem_rdata`  in  16  fetched instruction word.
- `if_valid`  out  1  `if_instr`/`if_pc`/`if_pc_plus_two` hold a valid instruction.
- `if_instr`  out  16  fetched instruction.
- `if_pc`  out  16  address of `if_instr`.
- `if_pc_plus_two`  out  16  `if_pc`+2, mod 2^16.
- `id_ready`  in  1  decode accepts; transfer when `if_valid & id_ready`.
- `halted`  out  1  HLT accepted by decode; fetching stopped.

## Operation
- States: REQ, BUF, HALT_PEND, HALT.
- Reset: state=REQ, pc=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_instr`/`if_pc`=0, `if_pc_plus_two`=2, `halted`=0, squash=0.
- REQ: `imem_req`=1, `imem_addr`=pc. On `imem_ack` (squash=0): capture `imem_rdata`→`if_instr`, pc→`if_pc`, pc+2→pc, `if_valid`←1; next state HALT_PEND if `imem_rdata[15:12]`==OPC_HLT, else BUF. On `imem_ack` with squash=1: discard data, clear squash, stay REQ (new request at redirected pc next cycle).
- BUF: `imem_req`=0, `if_valid`=1; on `id_ready`: `if_valid`←0, →REQ.
- HALT_PEND: as BUF, but acceptance →HALT and `halted`←1.
- HALT: no requests, `if_valid`=0, `halted`=1; only reset exits.
- Redirect (any state except HALT), highest priority:
  - pc←`{redirect_pc[15:1],1'b0}`, `if_valid`←0, next state REQ.
  - If a request is outstanding without `imem_ack` this cycle: `imem_req`/`imem_addr` keep old values until ack (handshake never abandoned), squash←1.
  - If `imem_ack` coincides with redirect: data discarded, squash stays 0.
  - Redirect in BUF/HALT_PEND coinciding with `id_ready`: instruction counts as consumed; redirect still applied; HALT not entered.
  - Redirect in HALT ignored.
- PC arithmetic: unsigned 16-bit, wraps: 16'hFFFE+2 = 16'h0000.

## Timing
- All outputs registered except `imem_req`/`imem_addr` (decoded from state and registered pc/held address, glitch-free).
- Fetch latency: `imem_ack` in cycle N → `if_valid`=1 in N+1.
- Zero-wait memory throughput: one instruction per 2 cycles (REQ, BUF alternating) with `id_ready` held high.
- Redirect at cycle N → new-target request visible at N+1 if no request pending, else at cycle after the pending ack.
- `halted` rises the cycle after HLT is accepted.
- Reset mid-request drops `imem_req` next cycle; memory must tolerate abandoned requests on reset only.

## Structure
- Shared package `wisc_isa_pkg`: `OPC_HLT` (4'hF), `fetch_state_t` enum {REQ, BUF, HALT_PEND, HALT}, default reset PC constant.
- Reuse the existing `rca_16bit` as the single sub-module for pc+2 (cin=0, cout unused); `if_pc_plus_two` registered from the same sum.

## Test plan
- Reset release, zero-wait memory returning 16'h1234 at 0, 16'h5678 at 2, `id_ready`=1 -> addresses 0, 2, 4 requested; `if_instr`=16'h1234 with `if_pc`=0, `if_pc_plus_two`=2, then 16'h5678, one per 2 cycles.
- 3-cycle memory latency, `id_ready`=0 for 4 cycles after valid -> `imem_addr` stable for 3 cycles; `if_valid` held, outputs unchanged until accept.
- Redirect to 16'h0041 while request at 16'h0010 pending -> old request held until ack, data discarded, next request at 16'h0040, `if_valid` stays 0 in between.
- Redirect coincident with `imem_ack` -> data dropped, next request at target next cycle.
- Fetch 16'hF000 -> presented once; after accept `halted`=1, no further `imem_req`; redirect ignored; `rst_n`=0 restarts at `RESET_PC`.
- PC at 16'hFFFE, non-branch fetch -> `if_pc_plus_two`=0, next request address 16'h0000.

Source files
------------

// File: rtl/wisc_isa_pkg.sv
// wisc_isa_pkg: shared ISA constants, fetch-stage state type and PC helpers
package wisc_isa_pkg;
    localparam logic [3:0]  OPC_HLT          = 4'hF;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {REQ, BUF, HALT_PEND, HALT} fetch_state_t;

    function automatic logic [15:0] align_pc(input logic [15:0] addr);
        return {addr[15:1], 1'b0};
    endfunction

    function automatic logic is_hlt(input logic [15:0] instr);
        return instr[15:12] == OPC_HLT;
    endfunction
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: redirect, instruction-memory and decode handshakes of the fetch stage
interface pc_fetch_unit_if;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus_two;
    logic        id_ready;
    logic        halted;

    modport master (
        input  redirect_valid, redirect_pc, imem_ack, imem_rdata, id_ready,
        output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus_two, halted
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_ack, imem_rdata, id_ready,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus_two, halted
    );
endinterface

// File: rtl/rca_16bit.sv
// rca_16bit: 16-bit ripple-carry adder
module rca_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [16:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[16];
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch front end owning the PC; issues imem requests,
// buffers one instruction for decode and stops fetching after HLT.
module pc_fetch_unit
    import wisc_isa_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_fetch_unit_if.master bus
);
    fetch_state_t state, state_d;
    logic         live, squash, squash_d, valid_d, halted_d, ack, redir, unused_cout;
    logic [15:0]  pc, pc_d, hold_addr, hold_d, pc_sum, instr_d, ipc_d, ipc2_d;

    rca_16bit u_pc_inc (.a(pc), .b(16'd2), .cin(1'b0), .sum(pc_sum), .cout(unused_cout));

    // live keeps imem_req low while reset is held; a squashed request keeps its address until acked
    assign bus.imem_req  = live && state == REQ;
    assign bus.imem_addr = squash ? hold_addr : pc;
    assign ack           = bus.imem_req && bus.imem_ack;
    assign redir         = bus.redirect_valid && state != HALT;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= REQ;
        else        state <= state_d;
    end

    always_comb begin
        state_d  = state;
        pc_d     = pc;
        hold_d   = hold_addr;
        squash_d = squash;
        valid_d  = bus.if_valid;
        halted_d = bus.halted;
        instr_d  = bus.if_instr;
        ipc_d    = bus.if_pc;
        ipc2_d   = bus.if_pc_plus_two;
        if (redir) begin
            state_d  = REQ;
            pc_d     = align_pc(bus.redirect_pc);
            valid_d  = 1'b0;
            squash_d = bus.imem_req && !bus.imem_ack;
            hold_d   = bus.imem_addr;
        end else if (ack) begin
            squash_d = 1'b0;
            if (!squash) begin
                state_d = is_hlt(bus.imem_rdata) ? HALT_PEND : BUF;
                pc_d    = pc_sum;
                valid_d = 1'b1;
                instr_d = bus.imem_rdata;
                ipc_d   = pc;
                ipc2_d  = pc_sum;
            end
        end else if ((state == BUF || state == HALT_PEND) && bus.id_ready) begin
            state_d  = state == HALT_PEND ? HALT : REQ;
            valid_d  = 1'b0;
            halted_d = state == HALT_PEND;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live               <= 1'b0;
            pc                 <= RESET_PC;
            hold_addr          <= RESET_PC;
            squash             <= 1'b0;
            bus.if_valid       <= 1'b0;
            bus.if_instr       <= '0;
            bus.if_pc          <= '0;
            bus.if_pc_plus_two <= 16'd2;
            bus.halted         <= 1'b0;
        end else begin
            live               <= 1'b1;
            pc                 <= pc_d;
            hold_addr          <= hold_d;
            squash             <= squash_d;
            bus.if_valid       <= valid_d;
            bus.if_instr       <= instr_d;
            bus.if_pc          <= ipc_d;
            bus.if_pc_plus_two <= ipc2_d;
            bus.halted         <= halted_d;
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized bench against a transaction-level model of the fetch stream
module tb_pc_fetch_unit;
    localparam logic [15:0] RST_PC = 16'h0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    pc_fetch_unit_if bus();
    pc_fetch_unit #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] mem [0:32767];
    // model: started = out of reset, bv = decode buffer full, outst = request in flight, disc = its data is dead
    bit started, m_halted, bv, outst, disc;
    logic [15:0] npc, oaddr, b_instr, b_pc;
    int lat_cfg = -1;
    int lat = 0;
    int wcnt = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic bit m_req();
        return started && !m_halted && !bv;
    endfunction

    function automatic logic [15:0] m_cur();
        return outst ? oaddr : npc;
    endfunction

    task automatic set_lat(input int l);
        lat_cfg = l;
        lat = l < 0 ? int'($urandom_range(0, 3)) : l;
        wcnt = 0;
    endtask

    task automatic observe();
        @(negedge clk);
        check("imem_req", {15'd0, bus.imem_req}, {15'd0, m_req()});
        if (!bv && !m_halted) check("imem_addr", bus.imem_addr, m_cur());
        check("if_valid", {15'd0, bus.if_valid}, {15'd0, bv});
        check("halted", {15'd0, bus.halted}, {15'd0, m_halted});
        if (bv) begin
            check("if_instr", bus.if_instr, b_instr);
            check("if_pc", bus.if_pc, b_pc);
            check("if_pc_plus_two", bus.if_pc_plus_two, b_pc + 16'd2);
        end
    endtask

    task automatic apply(input bit rv, input bit rd, input logic [15:0] tgt, input bit rdy);
        bit req, a, ackv;
        logic [15:0] cur;
        req = m_req();
        cur = m_cur();
        ackv = 1'b0;
        if (rv && bus.imem_req) begin
            if (wcnt >= lat) begin
                ackv = 1'b1;
                wcnt = 0;
                lat = lat_cfg < 0 ? int'($urandom_range(0, 3)) : lat_cfg;
            end else wcnt++;
        end else wcnt = 0;
        rst_n = rv;
        bus.redirect_valid = rd;
        bus.redirect_pc = tgt;
        bus.id_ready = rdy;
        bus.imem_ack = ackv;
        bus.imem_rdata = ackv ? mem[bus.imem_addr[15:1]] : 16'($urandom);
        if (!rv) begin
            started = 0; m_halted = 0; bv = 0; outst = 0; disc = 0; npc = RST_PC;
        end else begin
            a = req && ackv;
            if (rd && !m_halted) begin
                if (req && !a) begin
                    oaddr = cur; outst = 1; disc = 1;
                end else begin
                    outst = 0; disc = 0;
                end
                npc = {tgt[15:1], 1'b0};
                bv = 0;
            end else if (a) begin
                if (!disc) begin
                    bv = 1; b_instr = mem[cur[15:1]]; b_pc = cur; npc = cur + 16'd2;
                end
                outst = 0; disc = 0;
            end else if (req) begin
                oaddr = cur; outst = 1;
            end else if (bv && rdy) begin
                bv = 0;
                m_halted = b_instr[15:12] == 4'hF;
            end
            started = 1;
        end
    endtask

    task automatic step(input bit rv, input bit rd, input logic [15:0] tgt, input bit rdy);
        observe();
        apply(rv, rd, tgt, rdy);
    endtask

    initial begin
        bit done;
        int hcnt;
        logic [15:0] w;
        started = 0; m_halted = 0; bv = 0; outst = 0; disc = 0; npc = RST_PC;
        oaddr = RST_PC; b_instr = '0; b_pc = '0;
        bus.redirect_valid = 0; bus.redirect_pc = '0; bus.imem_ack = 0;
        bus.imem_rdata = '0; bus.id_ready = 0;
        for (int i = 0; i < 32768; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF && $urandom_range(0, 3) != 0) w[15:12] = 4'h0;
            mem[i] = w;
        end
        mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h2222; mem[3] = 16'h3333;
        mem[16'h0080] = 16'hF000;
        mem[16'h7FFF] = 16'h1111;

        // zero-wait stream from reset
        set_lat(0);
        repeat (3) step(0, 0, '0, 1);
        check("rst_if_instr", bus.if_instr, 16'h0000);
        check("rst_if_pc", bus.if_pc, 16'h0000);
        check("rst_if_pc_plus_two", bus.if_pc_plus_two, 16'h0002);
        repeat (8) step(1, 0, '0, 1);

        // slow memory, decode stalls
        set_lat(2);
        repeat (2) step(0, 0, '0, 0);
        repeat (12) step(1, 0, '0, 0);
        repeat (6) step(1, 0, '0, 1);

        // redirect to odd target while a request is pending
        set_lat(3);
        repeat (2) step(0, 0, '0, 1);
        step(1, 1, 16'h0010, 1);
        step(1, 0, '0, 1);
        step(1, 1, 16'h0041, 1);
        repeat (12) step(1, 0, '0, 1);

        // redirect coinciding with a zero-wait ack
        set_lat(0);
        repeat (2) step(0, 0, '0, 1);
        repeat (3) step(1, 0, '0, 1);
        done = 0;
        for (int i = 0; i < 4 && !done; i++) begin
            observe();
            if (bus.imem_req) begin
                apply(1, 1, 16'h0080, 1);
                done = 1;
            end else apply(1, 0, '0, 1);
        end
        check("redir_ack_seen", {15'd0, done}, 16'd1);
        repeat (6) step(1, 0, '0, 1);

        // HLT: halt, ignore redirect, restart from reset
        set_lat(1);
        repeat (2) step(0, 0, '0, 1);
        step(1, 1, 16'h0100, 1);
        repeat (8) step(1, 0, '0, 1);
        check("halted_after_hlt", {15'd0, bus.halted}, 16'd1);
        repeat (3) step(1, 1, 16'h0200, 1);
        repeat (3) step(1, 0, '0, 1);
        repeat (2) step(0, 0, '0, 1);
        repeat (6) step(1, 0, '0, 1);

        // PC wrap at 16'hFFFE
        set_lat(0);
        repeat (2) step(0, 0, '0, 1);
        step(1, 1, 16'hFFFF, 1);
        repeat (8) step(1, 0, '0, 1);

        // random traffic
        set_lat(-1);
        hcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            hcnt = m_halted ? hcnt + 1 : 0;
            step(!(hcnt > 4) && $urandom_range(0, 299) != 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 7) == 0 ? (16'hFFF0 | 16'($urandom_range(0, 15))) : 16'($urandom),
                 $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
